// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-configurable serial pattern detector with a registered one-cycle detect pulse.
// Define SEQDET_CNT_EN to build the saturating match counter; otherwise match_count/count_sat are tied low.
module seq_detect_param #(
    parameter int                 MAX_LEN         = 8,
    parameter int                 CNT_W           = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(8'b0000_0110),
    parameter int                 DEFAULT_LEN     = 3,
    parameter bit                 DEFAULT_OVERLAP = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic                           seq_in,
    input  logic                           cfg_load,
    input  logic [MAX_LEN-1:0]             cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
    input  logic                           cfg_overlap,
    input  logic                           cnt_clr,
    output logic                           detected_out,
    output logic                           armed,
    output logic                           cfg_err,
    output logic [CNT_W-1:0]               match_count,
    output logic                           count_sat
);
    localparam int                LEN_W     = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]  DEF_LEN_L = LEN_W'(DEFAULT_LEN);

    typedef enum logic {FILL, HUNT} state_t;

    state_t               state_q, state_d;
    logic [MAX_LEN-1:0]   pattern_q, pattern_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 overlap_q, overlap_d;
    logic [MAX_LEN-1:0]   hist_q, hist_d;
    logic [LEN_W-1:0]     fill_q, fill_d;
    logic                 detected_q, cfg_err_q, cfg_err_d;
    logic                 match;
    logic                 cfg_ok;
    logic [MAX_LEN-1:0]   hist_shift;
    logic [LEN_W-1:0]     fill_inc;

    function automatic logic [LEN_W-1:0] fill_sat_inc(input logic [LEN_W-1:0] f);
        return (f == MAX_LEN_L) ? f : f + 1'b1;
    endfunction

    // Selects the low n bits of the history for comparison.
    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] n);
        logic [MAX_LEN-1:0] m;
        for (int i = 0; i < MAX_LEN; i++)
            m[i] = (LEN_W'(i) < n);
        return m;
    endfunction

    assign cfg_ok     = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
    assign hist_shift = {hist_q[MAX_LEN-2:0], seq_in};
    assign fill_inc   = fill_sat_inc(fill_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FILL;
            pattern_q  <= DEFAULT_PATTERN;
            len_q      <= DEF_LEN_L;
            overlap_q  <= DEFAULT_OVERLAP;
            hist_q     <= '0;
            fill_q     <= '0;
            detected_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            len_q      <= len_d;
            overlap_q  <= overlap_d;
            hist_q     <= hist_d;
            fill_q     <= fill_d;
            detected_q <= match;
            cfg_err_q  <= cfg_err_d;
        end
    end

    // Any cfg_load strobe, accepted or rejected, takes priority and drops the coincident bit.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match     = 1'b0;
        cfg_err_d = 1'b0;
        if (cfg_load) begin
            if (cfg_ok) begin
                pattern_d = cfg_pattern;
                len_d     = cfg_len;
                overlap_d = cfg_overlap;
                hist_d    = '0;
                fill_d    = '0;
                state_d   = FILL;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (in_valid) begin
            hist_d  = hist_shift;
            fill_d  = fill_inc;
            match   = (fill_inc >= len_q) &&
                      (((hist_shift ^ pattern_q) & len_mask(len_q)) == '0);
            state_d = (fill_inc >= len_q) ? HUNT : FILL;
            if (match && !overlap_q) begin
                fill_d  = '0;
                state_d = FILL;
            end
        end
    end

    assign detected_out = detected_q;
    assign cfg_err      = cfg_err_q;
    assign armed        = (state_q == HUNT);

`ifdef SEQDET_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Clear beats a coincident match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else if (match) begin
            cnt_q <= cnt_sat_inc(cnt_q);
            sat_q <= sat_q | (&cnt_sat_inc(cnt_q));
        end
    end

    assign match_count = cnt_q;
    assign count_sat   = sat_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_count    = '0;
    assign count_sat      = 1'b0;
`endif

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial pattern detector; next generation of the fixed "110" Moore detector.
- Pattern, pattern length (1..MAX_LEN) and overlap mode are runtime-loadable.
- Qualified input stream via in_valid; registered Moore-style detect pulse; saturating match counter.
- Used on serial control/sniffer paths in front of protocol FSMs.

Parameters:
- MAX_LEN, 8, width of history/pattern registers (>=2).
- CNT_W, 8, width of match counter.
- DEFAULT_PATTERN, 8'b0000_0110, pattern loaded at reset (LSB-aligned, MSB-first order).
- DEFAULT_LEN, 3, pattern length at reset (1..MAX_LEN).
- DEFAULT_OVERLAP, 1, overlap mode at reset (1 = overlapping matches allowed).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state to defaults
- in_valid  in  1  seq_in sampled only when high
- seq_in  in  1  serial data bit
- cfg_load  in  1  single-cycle strobe: latch cfg_* fields
- cfg_pattern  in  MAX_LEN  new pattern; bit [cfg_len-1] is the first bit received
- cfg_len  in  $clog2(MAX_LEN+1)  new pattern length
- cfg_overlap  in  1  new overlap mode
- cnt_clr  in  1  synchronous clear of match_count/count_sat
- detected_out  out  1  one-cycle registered detect pulse
- armed  out  1  high when history holds >= len valid bits (FSM in HUNT)
- cfg_err  out  1  one-cycle pulse: cfg_load rejected
- match_count  out  CNT_W  number of matches since reset/cnt_clr
- count_sat  out  1  sticky: match_count reached all-ones

Behaviour:
- Reset: pattern/len/overlap = DEFAULT_*; history = 0; fill = 0; FSM = FILL; all outputs 0.
- Accepted bit (in_valid=1 at edge): hist <= {hist[MAX_LEN-2:0], seq_in}; fill increments, saturating at MAX_LEN.
- Match: accepted bit, fill_next >= len, and hist_next[len-1:0] == pattern[len-1:0].
- Latency: detected_out rises on the same edge that accepts the completing bit; high exactly one cycle. Never combinational from seq_in.
- No in_valid: history, fill, FSM hold; detected_out returns to 0.
- FSM states:
  - FILL: fill < len. Goes to HUNT when fill_next >= len.
  - HUNT: every accepted bit is compared against the pattern.
  - On a match with overlap=1: stay in HUNT; history kept.
  - On a match with overlap=0: fill <= 0 and go to FILL (matched bits are consumed).
- armed = (state == HUNT).
- len = 1 is legal: in HUNT from the first bit; every matching bit pulses.
- cfg_load with 1 <= cfg_len <= MAX_LEN:
  - Latch pattern/len/overlap.
  - Clear history and fill; FSM -> FILL; detected_out <= 0.
  - match_count is unchanged.
- cfg_load with cfg_len = 0 or > MAX_LEN: config unchanged, nothing cleared, cfg_err = 1 for one cycle.
- cfg_load and in_valid in the same cycle: load wins; the bit is discarded.
- Counter: match_count increments on each match, saturating at 2^CNT_W-1; count_sat sets on reaching all-ones.
- cnt_clr: clears counter and count_sat next edge. If a match occurs in the same cycle, clear wins and the count is 0.
- Reset mid-stream: immediate asynchronous return to reset state; partial history is lost.

Optional Feature:
- Macro SEQDET_CNT_EN.
- Defined: match_count/count_sat/cnt_clr implemented as above.
- Undefined: no counter flops; match_count tied 0, count_sat tied 0, cnt_clr ignored. Detection is unchanged.

Test Plan:
- Defaults, stream 1,1,0 with in_valid=1 -> detected_out high only on the cycle after the 0 is accepted; match_count=1; armed high from the 3rd bit.
- cfg_load pattern=101, len=3, overlap=1; stream 1,0,1,0,1 -> pulses after bits 3 and 5, count=2. Repeat with overlap=0 -> single pulse after bit 3, count=1.
- Defaults, stream 1,1,0 with in_valid low for 2 cycles between each bit -> exactly one pulse, aligned to the 0 acceptance; no pulse during gaps.
- cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err pulse each time; defaults still detect 110. cfg_load in the same cycle as in_valid -> bit dropped.
- CNT_W=2, 5 matches of 110 -> match_count=3 with count_sat=1; cnt_clr coincident with a match -> count 0.
- Assert reset after 1,1 -> all outputs 0 immediately. Then send 0 -> no detect; send 1,1,0 -> detect.
